// File: rtl/vend_pkg.sv
// Shared types and coin constants for the nickel/dime vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        VEND   = 2'b01,
        CHANGE = 2'b10
    } state_e;

    localparam int NICKEL = 5;
    localparam int DIME   = 10;

endpackage

// File: rtl/vend_coin_edge.sv
// Rising-edge detector for one coin sensor; the history register resets to 1
// so a sensor already high when reset releases is not seen as a coin.
module coin_edge (
    input  logic Clock,
    input  logic Resetn,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/vend_controller.sv
// Coin-credit accumulator and vend/change sequencer: accepts nickels and dimes
// up to a ceiling, handshakes the dispenser, then pays change one nickel at a time.
module vend_controller
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 35,
    parameter int CW         = 6,
    parameter int CHG_PERIOD = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          D,
    input  logic          N,
    input  logic          buy,
    input  logic          cancel,
    input  logic          disp_ack,
    output logic          disp_req,
    output logic          change_n,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);

    // One spare bit so the ceiling comparison never wraps.
    localparam int SW = CW + 1;
    localparam int PW = $clog2(CHG_PERIOD);
    localparam logic [PW-1:0] PACE_LAST = PW'(CHG_PERIOD - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic [PW-1:0] pace_q, pace_d;
    logic          disp_req_q, disp_req_d;
    logic          change_n_q, change_n_d;
    logic          coin_reject_q, coin_reject_d;

    logic          d_rise, n_rise;
    logic [SW-1:0] sum_v;
    logic [CW-1:0] rem_v;

    coin_edge u_dime_edge (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .level_i (D),
        .rise_o  (d_rise)
    );

    coin_edge u_nickel_edge (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .level_i (N),
        .rise_o  (n_rise)
    );

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        pace_d        = '0;
        change_n_d    = 1'b0;
        coin_reject_d = 1'b0;
        sum_v         = SW'(credit_q);
        rem_v         = credit_q - CW'(PRICE);

        unique case (state_q)
            IDLE: begin
                // Dime first; the nickel is judged against the credit including it.
                if (d_rise) begin
                    if (sum_v + SW'(DIME) <= SW'(MAX_CREDIT)) sum_v = sum_v + SW'(DIME);
                    else                                      coin_reject_d = 1'b1;
                end
                if (n_rise) begin
                    if (sum_v + SW'(NICKEL) <= SW'(MAX_CREDIT)) sum_v = sum_v + SW'(NICKEL);
                    else                                        coin_reject_d = 1'b1;
                end
                credit_d = sum_v[CW-1:0];
                if (cancel && sum_v != '0) begin
                    state_d = CHANGE;
                end else if (buy && sum_v >= SW'(PRICE)) begin
                    state_d = VEND;
                end
            end

            VEND: begin
                coin_reject_d = d_rise | n_rise;
                if (disp_ack) begin
                    credit_d = rem_v;
                    state_d  = (rem_v != '0) ? CHANGE : IDLE;
                end
            end

            CHANGE: begin
                coin_reject_d = d_rise | n_rise;
                if (pace_q == '0) begin
                    change_n_d = 1'b1;
                    credit_d   = credit_q - CW'(NICKEL);
                    pace_d     = PACE_LAST;
                    if (credit_q <= CW'(NICKEL)) state_d = IDLE;
                end else begin
                    pace_d = pace_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        disp_req_d = (state_d == VEND);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            pace_q        <= '0;
            disp_req_q    <= 1'b0;
            change_n_q    <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            pace_q        <= pace_d;
            disp_req_q    <= disp_req_d;
            change_n_q    <= change_n_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    assign disp_req    = disp_req_q;
    assign change_n    = change_n_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = (state_q != IDLE);

endmodule
